// File: rtl/fa_if.sv
// Bundle of the full-adder and sine/cosine datapath signals.
// The block drives from the slave side; its stimulus source uses master.
interface fa_if;
  logic        a;
  logic        b;
  logic        c;
  logic        s;
  logic        ca;
  logic [0:15] theta;
  logic [0:15] sine;
  logic [0:15] cos;

  modport master (output a, b, c, theta, input s, ca, sine, cos);
  modport slave  (input a, b, c, theta, output s, ca, sine, cos);
endinterface

// File: rtl/fa.sv
// Combinational full adder plus a 17-register rotation-mode CORDIC producing
// Q1.14 sine/cosine of a 16-bit binary angle, one result per clock.
module fa (
  input  logic clk,
  input  logic rst_n,
  fa_if.slave  bus
);

  // x/y carry 4 guard bits below the Q1.14 output LSB; z carries 4 guard bits
  // below the binary-angle LSB, so the arctan table is in angle units * 16.
  localparam int XW = 22;
  localparam int ZW = 20;
  localparam int NROT = 15;
  localparam logic signed [XW-1:0] X0 = 22'sd159184;  // 9949 << 4
  localparam logic signed [XW-1:0] OUT_MAX = 22'sd16388;
  localparam logic signed [XW-1:0] OUT_MIN = -22'sd16388;

  function automatic logic signed [ZW-1:0] atan_lut(input int i);
    case (i)
      0:       atan_lut = 20'sd131072;
      1:       atan_lut = 20'sd77376;
      2:       atan_lut = 20'sd40884;
      3:       atan_lut = 20'sd20753;
      4:       atan_lut = 20'sd10417;
      5:       atan_lut = 20'sd5213;
      6:       atan_lut = 20'sd2607;
      7:       atan_lut = 20'sd1304;
      8:       atan_lut = 20'sd652;
      9:       atan_lut = 20'sd326;
      10:      atan_lut = 20'sd163;
      11:      atan_lut = 20'sd81;
      12:      atan_lut = 20'sd41;
      13:      atan_lut = 20'sd20;
      default: atan_lut = 20'sd10;
    endcase
  endfunction

  // Drop the guard bits with round-half-up, then clamp to the legal output band.
  function automatic logic [15:0] to_out(input logic signed [XW-1:0] v);
    logic signed [XW-1:0] r;
    r = (v + 22'sd8) >>> 4;
    if (r > OUT_MAX)      to_out = 16'h4004;
    else if (r < OUT_MIN) to_out = 16'hBFFC;
    else                  to_out = r[15:0];
  endfunction

  assign bus.s  = bus.a ^ bus.b ^ bus.c;
  assign bus.ca = (bus.a & bus.b) | (bus.a & bus.c) | (bus.b & bus.c);

  logic [15:0] th;
  logic        flip;
  logic [15:0] z_fold;

  // Quadrants 1 and 2 are rotated by 180 deg: start from -x0 and fold the
  // angle into -90..+90 by flipping the MSB.
  assign th     = bus.theta;
  assign flip   = th[15] ^ th[14];
  assign z_fold = flip ? (th ^ 16'h8000) : th;

  logic signed [XW-1:0] x_q [0:NROT];
  logic signed [XW-1:0] y_q [0:NROT];
  logic signed [ZW-1:0] z_q [0:NROT-1];
  logic signed [XW-1:0] x_d [1:NROT];
  logic signed [XW-1:0] y_d [1:NROT];
  logic signed [ZW-1:0] z_d [1:NROT-1];
  logic [15:0]          sine_q;
  logic [15:0]          cos_q;

  // NOTE: every array element is assigned on every pass through this block,
  // so no stale value can be held and no latch is inferred.
  always_comb begin
    for (int i = 0; i < NROT; i++) begin
      if (!z_q[i][ZW-1]) begin
        x_d[i+1] = x_q[i] - (y_q[i] >>> i);
        y_d[i+1] = y_q[i] + (x_q[i] >>> i);
      end else begin
        x_d[i+1] = x_q[i] + (y_q[i] >>> i);
        y_d[i+1] = y_q[i] - (x_q[i] >>> i);
      end
    end
    // The last rotation only needs the sign of z, so z stops one stage early.
    for (int i = 0; i < NROT - 1; i++) begin
      if (!z_q[i][ZW-1]) z_d[i+1] = z_q[i] - atan_lut(i);
      else               z_d[i+1] = z_q[i] + atan_lut(i);
    end
  end

  // NOTE: the pipeline arrays are reset on purpose: in-flight results must be
  // discarded and the outputs must read zero until fresh data arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NROT; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
      for (int i = 0; i < NROT; i++) z_q[i] <= '0;
      sine_q <= '0;
      cos_q  <= '0;
    end else begin
      // NOTE: non-blocking updates let every stage read the previous cycle's
      // value of its predecessor, which is what makes this a pipeline.
      x_q[0] <= flip ? -X0 : X0;
      y_q[0] <= '0;
      z_q[0] <= {z_fold, 4'b0000};
      for (int i = 1; i <= NROT; i++) begin
        x_q[i] <= x_d[i];
        y_q[i] <= y_d[i];
      end
      for (int i = 1; i < NROT; i++) z_q[i] <= z_d[i];
      sine_q <= to_out(y_q[NROT]);
      cos_q  <= to_out(x_q[NROT]);
    end
  end

  assign bus.sine = sine_q;
  assign bus.cos  = cos_q;

endmodule

// File: tb/tb_fa.sv
// Bench for fa: exhaustive adder sweep, and a scoreboard of sine/cosine
// expectations that each come due 16 edges after the edge that sampled theta.
module tb_fa;

  localparam int LAT = 16;
  localparam int TOL = 4;
  localparam real PI = 3.14159265358979323846;

  typedef struct {
    logic [15:0] th;
    int          es;
    int          ec;
    int          due;
  } exp_t;

  logic clk;
  logic rst_n;
  fa_if bus ();

  fa dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  int   checks;
  int   errors;
  int   cyc;
  int   zero_until;
  int   cur_es;
  int   cur_ec;

  function automatic int ref_sin(input logic [15:0] th);
    real ang;
    ang = 2.0 * PI * real'(th) / 65536.0;
    return int'($floor(16384.0 * $sin(ang) + 0.5));
  endfunction

  function automatic int ref_cos(input logic [15:0] th);
    real ang;
    ang = 2.0 * PI * real'(th) / 65536.0;
    return int'($floor(16384.0 * $cos(ang) + 0.5));
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic set_theta(input logic [15:0] th);
    bus.theta = th;
    cur_es    = ref_sin(th);
    cur_ec    = ref_cos(th);
  endtask

  task automatic set_theta_exp(input logic [15:0] th, input int es, input int ec);
    bus.theta = th;
    cur_es    = es;
    cur_ec    = ec;
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if (bus.sine !== 16'h0000 || bus.cos !== 16'h0000) begin
      errors++;
      $display("FAIL %s cyc=%0d sine=%h cos=%h required 0000/0000", tag, cyc, bus.sine, bus.cos);
    end
  endtask

  // One clock: record what the DUT sampled, then compare whatever is due.
  task automatic tick();
    exp_t e;
    logic signed [15:0] gs;
    logic signed [15:0] gc;
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      e.th  = bus.theta;
      e.es  = cur_es;
      e.ec  = cur_ec;
      e.due = cyc + LAT;
      sb.push_back(e);
    end
    #1;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e  = sb.pop_front();
      gs = bus.sine;
      gc = bus.cos;
      checks++;
      if ($isunknown(bus.sine) || iabs(int'(gs) - e.es) > TOL) begin
        errors++;
        $display("FAIL sine th=%h got %0d required %0d+/-%0d", e.th, gs, e.es, TOL);
      end
      checks++;
      if ($isunknown(bus.cos) || iabs(int'(gc) - e.ec) > TOL) begin
        errors++;
        $display("FAIL cos th=%h got %0d required %0d+/-%0d", e.th, gc, e.ec, TOL);
      end
    end else if (!rst_n || cyc <= zero_until) begin
      check_zero("zero_window");
    end
  endtask

  task automatic test_adder();
    logic [1:0] want;
    for (int i = 0; i < 8; i++) begin
      bus.a = i[2];
      bus.b = i[1];
      bus.c = i[0];
      want  = 2'(i[2]) + 2'(i[1]) + 2'(i[0]);
      #1;
      checks++;
      if ({bus.ca, bus.s} !== want) begin
        errors++;
        $display("FAIL adder abc=%b got ca,s=%b%b required %b", i[2:0], bus.ca, bus.s, want);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_theta(16'h1234);
    #1;
    check_zero("reset_async");
    for (int i = 0; i < 3; i++) tick();
    // s/ca must work with the pipeline held in reset
    test_adder();
    set_theta_exp(16'h0000, 0, 16384);
    rst_n = 1'b1;
    zero_until = cyc + LAT;
    for (int i = 0; i < LAT + 2; i++) tick();
  endtask

  task automatic test_cardinal();
    logic [15:0] th_tab [5] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h2000};
    int          es_tab [5] = '{0, 16384, 0, -16384, 11585};
    int          ec_tab [5] = '{16384, 0, -16384, 0, 11585};
    for (int i = 0; i < 5; i++) begin
      set_theta_exp(th_tab[i], es_tab[i], ec_tab[i]);
      tick();
    end
  endtask

  task automatic test_boundaries();
    logic [15:0] th_tab [8] = '{16'h3FFF, 16'h4000, 16'h7FFF, 16'h8000,
                                16'hBFFF, 16'hC000, 16'hFFFF, 16'h0000};
    for (int i = 0; i < 8; i++) begin
      set_theta(th_tab[i]);
      tick();
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 65536; i++) begin
      set_theta(16'(i));
      tick();
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 40; i++) begin
      set_theta(16'($urandom));
      tick();
    end
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_zero("reset_midstream");
    for (int i = 0; i < 3; i++) tick();
    set_theta(16'($urandom));
    rst_n = 1'b1;
    zero_until = cyc + LAT;
    for (int i = 0; i < 40; i++) begin
      set_theta(16'($urandom));
      tick();
    end
  endtask

  task automatic drain();
    for (int i = 0; i < LAT + 1; i++) tick();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    cyc        = 0;
    zero_until = 0;
    cur_es     = 0;
    cur_ec     = 0;
    rst_n      = 1'b0;
    bus.a      = 1'b0;
    bus.b      = 1'b0;
    bus.c      = 1'b0;
    bus.theta  = 16'h0000;

    test_reset();
    test_cardinal();
    test_boundaries();
    test_back_to_back();
    test_reset_midstream();
    drain();
    test_adder();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fa.md
FA -- requirements
Module: fa

Interface
REQ-001 Parameters: none; all widths and the pipeline depth are fixed.
REQ-002 clk  input  1  single clock; all sequential logic samples on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 a  input  1  full-adder operand A.
REQ-005 b  input  1  full-adder operand B.
REQ-006 c  input  1  full-adder carry-in.
REQ-007 theta  input  [0:15]  angle, binary angle measure; bit 0 is MSB.
REQ-008 s  output  1  full-adder sum.
REQ-009 ca  output  1  full-adder carry-out.
REQ-010 sine  output  [0:15]  sin(theta), signed two's complement Q1.14; bit 0 is MSB/sign.
REQ-011 cos  output  [0:15]  cos(theta), same format as sine.

Function
REQ-012 s SHALL equal a XOR b XOR c, purely combinational, independent of clk and rst_n.
REQ-013 ca SHALL equal (a&b)|(a&c)|(b&c), purely combinational, independent of clk and rst_n.
REQ-014 theta SHALL be an unsigned full-circle angle: 0x0000=0 deg, 0x4000=90 deg, 0x8000=180 deg, 0xC000=270 deg; 1 LSB = 360/65536 deg; wraps naturally at 0xFFFF->0x0000.
REQ-015 Output scale: +1.0 = 0x4000 (16384), -1.0 = 0xC000.
REQ-016 Computation SHALL use a rotation-mode CORDIC: quadrant pre-fold (theta[0:1]) to -90..+90 deg, then 15 micro-rotations with arctan constants in the same angle units, x0 = 9949 (0x26DD, gain compensation), y0 = 0.
REQ-017 Internal x/y datapaths SHALL be at least 18 bits signed, with arithmetic right shifts; no internal overflow for any theta.
REQ-018 Fully pipelined: one new theta accepted every clock; no handshake, no stall.
REQ-019 Latency: theta sampled at rising edge k SHALL produce sine/cos on the outputs immediately after edge k+16; outputs are registered.
REQ-020 Accuracy: |sine - round(16384*sin(theta))| <= 4 LSB and likewise for cos, for all 65536 theta values.
REQ-021 Outputs SHALL be truncated/saturated to 16 bits, within 0xBFFC..0x4004; no wrap.
REQ-022 Quadrant boundaries (0x3FFF/0x4000, 0x7FFF/0x8000, 0xBFFF/0xC000, 0xFFFF/0x0000) SHALL meet REQ-020 with no sign glitch.
REQ-023 Back-to-back different theta values SHALL yield independent results in order, one per cycle.

Reset
REQ-024 rst_n low SHALL asynchronously clear every pipeline register; sine = cos = 0x0000 while rst_n is low.
REQ-025 After rst_n rises, sine/cos SHALL remain 0x0000 until the first theta sampled after release reaches the output (16 edges); no spurious nonzero values.
REQ-026 Reset asserted mid-stream SHALL discard all in-flight results; s/ca are unaffected by reset.

Verification
REQ-027 a,b,c swept over all 8 combinations -> {ca,s} = a+b+c (e.g. 1,1,1 -> ca=1, s=1; 1,0,1 -> ca=1, s=0).
REQ-028 theta=0x0000 held -> after 16 edges cos=0x4000+/-4, sine=0x0000+/-4.
REQ-029 theta=0x4000 -> sine=0x4000+/-4, cos=0+/-4; theta=0x8000 -> cos=0xC000+/-4; theta=0xC000 -> sine=0xC000+/-4.
REQ-030 theta=0x2000 (45 deg) -> sine=cos=11585 (0x2D41)+/-4.
REQ-031 Streamed theta 0x0000..0xFFFF, one per clock -> each output pair matches reference within 4 LSB, exactly 16 cycles later, in order.
REQ-032 rst_n pulsed low mid-stream -> outputs 0x0000 immediately, remain 0 for 16 edges after release, then valid results resume.
